// File: rtl/rrarb_hold.sv
// rtl/rrarb_hold.sv - round-robin arbiter with grant locking for multi-cycle bursts
// Owner keeps the grant until end of burst, dropped request, or the hold limit expires.
module rrarb_hold #(
  parameter  int NUM_REQ  = 4,
  parameter  int MAX_HOLD = 8,
  localparam int ID_W     = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               last_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]    gnt_id_o,
  output logic               busy_o,
  output logic               timeout_o
);

  localparam int HOLD_W = $clog2(MAX_HOLD);

  logic [NUM_REQ-1:0] r_gnt, w_gnt_nxt;
  logic [ID_W-1:0]    r_id, w_id_nxt;
  logic               r_busy, w_busy_nxt;
  logic               r_timeout, w_timeout_nxt;
  logic [ID_W-1:0]    r_ptr, w_ptr_nxt;
  logic [HOLD_W-1:0]  r_hold, w_hold_nxt;

  logic               w_release;
  logic [ID_W-1:0]    w_next_ptr;
  logic [NUM_REQ-1:0] w_mask;

  function automatic logic [ID_W-1:0] inc_idx(input logic [ID_W-1:0] k);
    return (int'(k) == NUM_REQ-1) ? '0 : ID_W'(int'(k) + 1);
  endfunction

  // First set bit of mask, scanning upward from p with wrap.
  function automatic logic [ID_W-1:0] pick(input logic [NUM_REQ-1:0] mask,
                                           input logic [ID_W-1:0]    p);
    logic [ID_W-1:0] idx;
    logic            found;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && mask[(int'(p) + i) % NUM_REQ]) begin
        idx   = ID_W'((int'(p) + i) % NUM_REQ);
        found = 1'b1;
      end
    end
    return idx;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_gnt     <= '0;
      r_id      <= '0;
      r_busy    <= 1'b0;
      r_timeout <= 1'b0;
      r_ptr     <= '0;
      r_hold    <= '0;
    end else begin
      r_gnt     <= w_gnt_nxt;
      r_id      <= w_id_nxt;
      r_busy    <= w_busy_nxt;
      r_timeout <= w_timeout_nxt;
      r_ptr     <= w_ptr_nxt;
      r_hold    <= w_hold_nxt;
    end
  end

  assign w_release  = last_i | ~req_i[r_id] | (r_hold == HOLD_W'(MAX_HOLD - 1));
  assign w_next_ptr = inc_idx(r_id);
  assign w_mask     = req_i & ~r_gnt;

  always_comb begin
    w_gnt_nxt     = r_gnt;
    w_id_nxt      = r_id;
    w_busy_nxt    = r_busy;
    w_timeout_nxt = 1'b0;
    w_ptr_nxt     = r_ptr;
    w_hold_nxt    = r_hold;
    if (!r_busy) begin
      if (|req_i) begin
        w_id_nxt   = pick(req_i, r_ptr);
        w_gnt_nxt  = NUM_REQ'(1) << pick(req_i, r_ptr);
        w_busy_nxt = 1'b1;
        w_hold_nxt = '0;
      end
    end else if (w_release) begin
      w_ptr_nxt     = w_next_ptr;
      w_hold_nxt    = '0;
      // Only a pure hold-limit release counts as a timeout.
      w_timeout_nxt = ~last_i & req_i[r_id];
      if (|w_mask) begin
        w_id_nxt   = pick(w_mask, w_next_ptr);
        w_gnt_nxt  = NUM_REQ'(1) << pick(w_mask, w_next_ptr);
        w_busy_nxt = 1'b1;
      end else begin
        w_id_nxt   = '0;
        w_gnt_nxt  = '0;
        w_busy_nxt = 1'b0;
      end
    end else begin
      w_hold_nxt = r_hold + 1'b1;
    end
  end

  always_comb begin
    gnt_o     = r_gnt;
    gnt_id_o  = r_id;
    busy_o    = r_busy;
    timeout_o = r_timeout;
  end

endmodule
